// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the RAM and the arbiter.
// The arbiter takes the slave view; whoever drives requests and models the RAM
// takes the master view.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        merr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, merr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, merr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between an instruction fetch side and a data side.
// Data normally wins; a saturating starve counter forces an instruction grant
// once STARVE_MAX data transactions have completed while a fetch was waiting.
// Only the FSM state and the starve counter are registered; RAM strobes and
// completion pulses are decoded combinationally from the current grant.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic         CLK,
  input logic         RST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RS_BUSY   = 2'b01;
  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;
  localparam logic [2:0] SMAX      = 3'(STARVE_MAX);

  state_t     state;
  logic [2:0] starve;

  logic dreq;
  logic force_i;
  logic dhit_c;
  logic ihit_c;
  logic err_c;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    sat_inc = (v >= SMAX) ? SMAX : v + 3'd1;
  endfunction

  // Request decode and completion conditions; a reset cycle never reports a hit or error
  always_comb begin
    dreq    = bus.dREN | bus.dWEN;
    force_i = bus.iREN && (starve == SMAX);
    dhit_c  = (state == DGRANT) && (bus.ramstate == RS_ACCESS) && dreq && !RST;
    ihit_c  = (state == IGRANT) && (bus.ramstate == RS_ACCESS) && bus.iREN && !RST;
    err_c   = (state != IDLE) && (bus.ramstate == RS_ERROR) && !RST;
  end

  // Arbitration FSM and starve counter; a grant ends on hit, error or requester drop
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !force_i)
            state <= DGRANT;
          else if (bus.iREN)
            state <= IGRANT;
        end
        DGRANT: begin
          if (dhit_c || !dreq || bus.ramstate == RS_ERROR)
            state <= IDLE;
          if (dhit_c)
            starve <= bus.iREN ? sat_inc(starve) : 3'd0;
        end
        IGRANT: begin
          if (ihit_c || !bus.iREN || bus.ramstate == RS_ERROR)
            state <= IDLE;
          if (ihit_c)
            starve <= 3'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM strobes, address mux and completion outputs for the current grant
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.dhit     = 1'b0;
    bus.ihit     = 1'b0;
    bus.dload    = '0;
    bus.iload    = '0;
    bus.merr     = err_c;
    case (state)
      DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dhit     = dhit_c;
        bus.dload    = (dhit_c && bus.ramREN) ? bus.ramload : '0;
      end
      IGRANT: begin
        bus.ramaddr  = bus.iaddr;
        bus.ramREN   = 1'b1;
        bus.ihit     = ihit_c;
        bus.iload    = ihit_c ? bus.ramload : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_mem_arbiter;

  localparam int SM = 4;

  logic CLK = 1'b0;
  logic RST;
  int   checks   = 0;
  int   failures = 0;
  bit   run_cmp  = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: who owns the RAM, and how long fetch has starved
  int owner  = 0;   // 0 nobody, 1 data side, 2 instruction side
  int starve = 0;

  always @(posedge CLK) begin
    bit dr;
    bit held;
    dr = bus.dREN || bus.dWEN;
    if (RST) begin
      owner  = 0;
      starve = 0;
    end else if (owner == 0) begin
      if (dr && !(bus.iREN && starve == SM)) owner = 1;
      else if (bus.iREN) owner = 2;
    end else begin
      held = (owner == 1) ? dr : bus.iREN;
      if (held && bus.ramstate == 2'b10) begin
        if (owner == 2) starve = 0;
        else starve = bus.iREN ? ((starve < SM) ? starve + 1 : SM) : 0;
      end
      // only a still-wanted grant on a FREE/BUSY RAM survives the edge
      if (!(held && bus.ramstate < 2'b10)) owner = 0;
    end
  end

  // Compare every output against the model each cycle, away from the edge
  always @(negedge CLK) begin
    logic [31:0] e_addr, e_store, e_dload, e_iload;
    logic e_ren, e_wen, e_dhit, e_ihit, e_merr;
    bit live;
    if (run_cmp) begin
      live = !RST;
      {e_addr, e_store, e_dload, e_iload} = '0;
      {e_ren, e_wen, e_dhit, e_ihit, e_merr} = '0;
      if (owner == 1) begin
        e_addr  = bus.daddr;
        e_store = bus.dstore;
        e_wen   = bus.dWEN;
        e_ren   = bus.dREN && !bus.dWEN;
        e_dhit  = live && bus.ramstate == 2'b10 && (bus.dREN || bus.dWEN);
        e_dload = (e_dhit && e_ren) ? bus.ramload : 32'h0;
        e_merr  = live && bus.ramstate == 2'b11;
      end else if (owner == 2) begin
        e_addr  = bus.iaddr;
        e_ren   = 1'b1;
        e_ihit  = live && bus.ramstate == 2'b10 && bus.iREN;
        e_iload = e_ihit ? bus.ramload : 32'h0;
        e_merr  = live && bus.ramstate == 2'b11;
      end
      cmp("m_ramaddr",  bus.ramaddr,  e_addr);
      cmp("m_ramstore", bus.ramstore, e_store);
      cmp("m_ramREN",   32'(bus.ramREN), 32'(e_ren));
      cmp("m_ramWEN",   32'(bus.ramWEN), 32'(e_wen));
      cmp("m_dhit",     32'(bus.dhit),   32'(e_dhit));
      cmp("m_ihit",     32'(bus.ihit),   32'(e_ihit));
      cmp("m_dload",    bus.dload,    e_dload);
      cmp("m_iload",    bus.iload,    e_iload);
      cmp("m_merr",     32'(bus.merr),   32'(e_merr));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'b00;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    bus.iREN = 1; bus.dREN = 1;           // requests present during reset
    run_cmp = 1'b1;
    tick(); tick();
    @(negedge CLK);
    cmp("rst_ramREN", 32'(bus.ramREN), 0);
    cmp("rst_dhit",   32'(bus.dhit),   0);
    tick();
    RST = 1'b0;
    clear_inputs();
    @(negedge CLK);

    // Single fetch, RAM answers immediately
    tick();
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = 2'b10; bus.ramload = 32'h8C010004;
    @(negedge CLK);
    cmp("t1_idle_ramREN", 32'(bus.ramREN), 0);
    tick();
    @(negedge CLK);
    cmp("t1_ihit",    32'(bus.ihit),   1);
    cmp("t1_iload",   bus.iload,       32'h8C010004);
    cmp("t1_ramREN",  32'(bus.ramREN), 1);
    cmp("t1_ramaddr", bus.ramaddr,     32'h40);
    tick();
    clear_inputs();

    // Simultaneous fetch and data read: data first, then fetch
    tick();
    bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h100;
    bus.ramstate = 2'b10; bus.ramload = 32'h11112222;
    tick();
    @(negedge CLK);
    cmp("t2_dhit",    32'(bus.dhit), 1);
    cmp("t2_ramaddr", bus.ramaddr,   32'h100);
    cmp("t2_dload",   bus.dload,     32'h11112222);
    tick();
    bus.dREN = 0;
    @(negedge CLK);
    cmp("t2_gap_ramREN", 32'(bus.ramREN), 0);
    tick();
    @(negedge CLK);
    cmp("t2_ihit",    32'(bus.ihit), 1);
    cmp("t2_iaddr",   bus.ramaddr,   32'h44);
    tick();
    clear_inputs();

    // Write held through three BUSY cycles, completes on the fourth
    tick();
    bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
    bus.ramstate = 2'b01; bus.ramload = 32'hFFFF0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.ramstate = (k == 3) ? 2'b10 : 2'b01;
      @(negedge CLK);
      cmp("t3_ramWEN",   32'(bus.ramWEN), 1);
      cmp("t3_dhit",     32'(bus.dhit),   (k == 3) ? 1 : 0);
      cmp("t3_ramstore", bus.ramstore,    32'hDEADBEEF);
      cmp("t3_dload",    bus.dload,       0);
    end
    tick();
    clear_inputs();

    // Read and write both asserted: write wins, no read data returned
    tick();
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h204; bus.ramstate = 2'b10;
    bus.ramload = 32'h12345678;
    tick();
    @(negedge CLK);
    cmp("t3b_ramREN", 32'(bus.ramREN), 0);
    cmp("t3b_ramWEN", 32'(bus.ramWEN), 1);
    cmp("t3b_dload",  bus.dload,       0);
    tick();
    clear_inputs();

    // Starvation: four data hits, then the waiting fetch is forced in
    tick();
    bus.iREN = 1; bus.iaddr = 32'h80; bus.dREN = 1; bus.daddr = 32'h300;
    bus.ramstate = 2'b10; bus.ramload = 32'h55AA55AA;
    for (int c = 0; c < 11; c++) begin
      tick();
      @(negedge CLK);
      cmp("t4_dhit", 32'(bus.dhit), ((c % 2 == 0) && c != 8) ? 1 : 0);
      cmp("t4_ihit", 32'(bus.ihit), (c == 8) ? 1 : 0);
    end
    tick();
    clear_inputs();

    // RAM error during a data grant
    tick();
    bus.dREN = 1; bus.daddr = 32'h400; bus.ramstate = 2'b11;
    @(negedge CLK);
    cmp("t5_idle_merr", 32'(bus.merr), 0);
    tick();
    @(negedge CLK);
    cmp("t5_merr", 32'(bus.merr), 1);
    cmp("t5_dhit", 32'(bus.dhit), 0);
    tick();
    clear_inputs();
    @(negedge CLK);
    cmp("t5_after_merr", 32'(bus.merr), 0);

    // Fetch withdrawn while RAM busy: abort without hit
    tick();
    bus.iREN = 1; bus.iaddr = 32'h90; bus.ramstate = 2'b01;
    tick();
    bus.iREN = 0;
    @(negedge CLK);
    cmp("t6_ihit", 32'(bus.ihit), 0);
    tick();
    bus.ramstate = 2'b10;
    @(negedge CLK);
    cmp("t6_idle_ramREN", 32'(bus.ramREN), 0);
    tick();
    clear_inputs();

    // Reset in the middle of a busy fetch; rearbitration after reset drops
    tick();
    bus.iREN = 1; bus.iaddr = 32'hA0; bus.ramstate = 2'b01; bus.ramload = 32'hCAFEF00D;
    tick();
    tick();
    RST = 1'b1;
    @(negedge CLK);
    cmp("t7_rst_ihit", 32'(bus.ihit), 0);
    tick();
    bus.ramstate = 2'b10;
    @(negedge CLK);
    cmp("t7_rst_idle_ihit",   32'(bus.ihit),   0);
    cmp("t7_rst_idle_ramREN", 32'(bus.ramREN), 0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    cmp("t7_first_idle", 32'(bus.ramREN), 0);
    tick();
    @(negedge CLK);
    cmp("t7_ihit",  32'(bus.ihit), 1);
    cmp("t7_iload", bus.iload,     32'hCAFEF00D);
    tick();
    clear_inputs();
    tick();
    @(negedge CLK);

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
